// File: rtl/bht_btb_ctrl.sv
// Purpose : direct-mapped BTB + 2-bit BHT branch predictor with post-reset table clear.
// Latency : prediction and redirect are 0-cycle (combinational); table writes land at the edge.
// Backpr. : none; UpdE is taken every cycle it is high (dropped while the clear walk runs).
//
// Ports:
//   CPU_CLK / CPU_RST_N        clock, synchronous active-low reset
//   PCF -> BranchFlagsF, PredTargetF   IF-stage prediction {hit, taken}
//   UpdE, PCE, BrTargetE, TakenE, BranchFlagsE -> RedirectE, RedirectPCE   EX resolve/update
//   ReadyO                     table clear finished, predictor active
//   BrCountO, MispredCountO    branch / mispredict counters (only with BP_STATS_EN defined)
//
// Optional feature macro: BP_STATS_EN

module bht_btb_ctrl #(
  parameter int ENTRIES_LOG2 = 6
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PCF,
  output logic [31:0] PredTargetF,
  output logic [1:0]  BranchFlagsF,
  input  logic        UpdE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        TakenE,
  input  logic [1:0]  BranchFlagsE,
  output logic        RedirectE,
  output logic [31:0] RedirectPCE,
  output logic        ReadyO
`ifdef BP_STATS_EN
  ,
  output logic [31:0] BrCountO,
  output logic [31:0] MispredCountO
`endif
);

  localparam int ENTRIES = 1 << ENTRIES_LOG2;
  localparam int TAG_W   = 30 - ENTRIES_LOG2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_nxt;
  logic [ENTRIES_LOG2-1:0] clr_idx_q, clr_idx_nxt;
  logic                    clr_en;
  logic                    upd_en;

  // Valid bits live apart from the payload: only they are cleared by the walk,
  // so tag/target/counter storage needs no reset or clear path.
  logic                    valid_q [ENTRIES];
  entry_t                  ent_q   [ENTRIES];

  // IF-side lookup
  logic [ENTRIES_LOG2-1:0] idx_f;
  logic [TAG_W-1:0]        tag_f;
  entry_t                  ent_f;
  logic                    match_f;

  assign idx_f   = PCF[ENTRIES_LOG2+1:2];
  assign tag_f   = PCF[31:ENTRIES_LOG2+2];
  assign ent_f   = ent_q[idx_f];
  assign match_f = valid_q[idx_f] && (ent_f.tag == tag_f);

  // EX-side lookup; hit is re-evaluated against the table as it stands now,
  // since the IF-time flags may be stale after an intervening update or eviction.
  logic [ENTRIES_LOG2-1:0] idx_e;
  logic [TAG_W-1:0]        tag_e;
  entry_t                  ent_e;
  logic                    hit_e;
  entry_t                  alloc_ent;

  assign idx_e = PCE[ENTRIES_LOG2+1:2];
  assign tag_e = PCE[31:ENTRIES_LOG2+2];
  assign ent_e = ent_q[idx_e];
  assign hit_e = valid_q[idx_e] && (ent_e.tag == tag_e);

  always_comb begin
    alloc_ent        = '0;
    alloc_ent.tag    = tag_e;
    alloc_ent.target = BrTargetE;
    alloc_ent.ctr    = 2'b10;
  end

  // Redirect: a mispredict is any disagreement between outcome and predicted
  // direction; flags 00 in INIT make every taken branch a redirect there.
  assign RedirectE   = UpdE && (TakenE != BranchFlagsE[0]);
  assign RedirectPCE = TakenE ? BrTargetE : (PCE + 32'd4);

  // FSM state register
  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_nxt;
      clr_idx_q <= clr_idx_nxt;
    end
  end

  // FSM next state and prediction outputs
  always_comb begin
    state_nxt    = state_q;
    clr_idx_nxt  = clr_idx_q;
    clr_en       = 1'b0;
    upd_en       = 1'b0;
    ReadyO       = 1'b0;
    BranchFlagsF = 2'b00;
    PredTargetF  = '0;
    case (state_q)
      INIT: begin
        clr_en      = 1'b1;
        clr_idx_nxt = clr_idx_q + 1'b1;
        if (&clr_idx_q) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        ReadyO       = 1'b1;
        upd_en       = UpdE;
        BranchFlagsF = {match_f, match_f & ent_f.ctr[1]};
        PredTargetF  = ent_f.target;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Table write port: clear walk in INIT, resolved-branch update in RUN.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST_N) begin
      if (clr_en) begin
        valid_q[clr_idx_q] <= 1'b0;
      end else if (upd_en) begin
        if (hit_e) begin
          if (TakenE) begin
            ent_q[idx_e].target <= BrTargetE;
            if (ent_e.ctr != 2'b11) begin
              ent_q[idx_e].ctr <= ent_e.ctr + 2'b01;
            end
          end else if (ent_e.ctr != 2'b00) begin
            ent_q[idx_e].ctr <= ent_e.ctr - 2'b01;
          end
        end else if (TakenE) begin
          // Allocate weakly-taken, overwriting whatever aliased into this slot.
          valid_q[idx_e] <= 1'b1;
          ent_q[idx_e]   <= alloc_ent;
        end
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (UpdE) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (RedirectE) begin
        mis_cnt_q <= mis_cnt_q + 32'd1;
      end
    end
  end

  assign BrCountO      = br_cnt_q;
  assign MispredCountO = mis_cnt_q;
`endif

  // Word-aligned PCs and the IF-time hit flag carry no information here.
  logic unused_bits;
  assign unused_bits = ^{PCF[1:0], PCE[1:0], BranchFlagsE[1]};

endmodule

// File: tb/tb_bht_btb_ctrl.sv
// Purpose : self-checking bench for bht_btb_ctrl against a table-of-branches reference model.
// Latency : checks combinational outputs mid-cycle, model advances at each rising edge.
// Backpr. : none.

module tb_bht_btb_ctrl;

  localparam int N   = 6;
  localparam int ENT = 1 << N;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N;
  logic [31:0] PCF;
  logic [31:0] PredTargetF;
  logic [1:0]  BranchFlagsF;
  logic        UpdE;
  logic [31:0] PCE;
  logic [31:0] BrTargetE;
  logic        TakenE;
  logic [1:0]  BranchFlagsE;
  logic        RedirectE;
  logic [31:0] RedirectPCE;
  logic        ReadyO;
`ifdef BP_STATS_EN
  logic [31:0] BrCountO;
  logic [31:0] MispredCountO;
`endif

  bht_btb_ctrl #(.ENTRIES_LOG2(N)) dut (
    .CPU_CLK      (CPU_CLK),
    .CPU_RST_N    (CPU_RST_N),
    .PCF          (PCF),
    .PredTargetF  (PredTargetF),
    .BranchFlagsF (BranchFlagsF),
    .UpdE         (UpdE),
    .PCE          (PCE),
    .BrTargetE    (BrTargetE),
    .TakenE       (TakenE),
    .BranchFlagsE (BranchFlagsE),
    .RedirectE    (RedirectE),
    .RedirectPCE  (RedirectPCE),
    .ReadyO       (ReadyO)
`ifdef BP_STATS_EN
    ,
    .BrCountO     (BrCountO),
    .MispredCountO(MispredCountO)
`endif
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: per slot, the full PC of the branch that owns it.
  bit          m_valid [ENT];
  bit [31:0]   m_pc    [ENT];
  bit [31:0]   m_tgt   [ENT];
  int          m_ctr   [ENT];
  int          since_release = 0;
  bit [31:0]   m_br = 0;
  bit [31:0]   m_mis = 0;

  // Values sampled mid-cycle by the last do_cycle
  logic [1:0]  obs_flags;
  logic [31:0] obs_tgt;
  logic        obs_redir;
  logic [31:0] obs_rpc;
  logic        obs_ready;

  bit [31:0] pool [8] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0104, 32'h0000_1100,
                          32'h0000_03FC, 32'hFFFF_FFFC, 32'h8000_0100, 32'h0000_002C};

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic bit [31:0] tag_of(bit [31:0] pc);
    return pc >> (N + 2);
  endfunction

  function automatic bit m_ready();
    return since_release >= ENT;
  endfunction

  function automatic bit m_hit(bit [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_ready() && m_valid[i] && (tag_of(m_pc[i]) == tag_of(pc));
  endfunction

  function automatic bit [1:0] m_flags(bit [31:0] pc);
    if (!m_hit(pc)) return 2'b00;
    return {1'b1, m_ctr[idx_of(pc)] >= 2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    CPU_RST_N = 1'b0;
    UpdE      = 1'b0;
    repeat (n) begin
      @(posedge CPU_CLK);
      #1;
    end
    CPU_RST_N     = 1'b1;
    since_release = 0;
    m_br          = 0;
    m_mis         = 0;
    for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
  endtask

  // One clock cycle: drive, check mid-cycle, advance model, cross the edge.
  task automatic do_cycle(input bit [31:0] pcf, input bit upd, input bit [31:0] pce,
                          input bit [31:0] tgt, input bit taken, input bit [1:0] fe);
    bit [1:0] ef;
    bit       exp_redir;
    int       i;
    PCF          = pcf;
    UpdE         = upd;
    PCE          = pce;
    BrTargetE    = tgt;
    TakenE       = taken;
    BranchFlagsE = fe;
    @(negedge CPU_CLK);
    obs_flags = BranchFlagsF;
    obs_tgt   = PredTargetF;
    obs_redir = RedirectE;
    obs_rpc   = RedirectPCE;
    obs_ready = ReadyO;
    ef        = m_flags(pcf);
    exp_redir = upd && (taken != fe[0]);
    chk("ready", obs_ready, m_ready());
    chk("flagsF", obs_flags, ef);
    if (ef == 2'b11) chk("pred_target", obs_tgt, m_tgt[idx_of(pcf)]);
    if (!m_ready()) chk("pred_target_init", obs_tgt, 32'd0);
    chk("redirect", obs_redir, exp_redir);
    chk("redirect_pc", obs_rpc, taken ? tgt : pce + 32'd4);
`ifdef BP_STATS_EN
    chk("br_count", BrCountO, m_br);
    chk("mispred_count", MispredCountO, m_mis);
`endif
    if (upd) begin
      m_br++;
      if (exp_redir) m_mis++;
    end
    if (upd && m_ready()) begin
      i = idx_of(pce);
      if (m_hit(pce)) begin
        if (taken) begin
          if (m_ctr[i] < 3) m_ctr[i]++;
          m_tgt[i] = tgt;
        end else if (m_ctr[i] > 0) begin
          m_ctr[i]--;
        end
      end else if (taken) begin
        m_valid[i] = 1'b1;
        m_pc[i]    = pce;
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end
    since_release++;
    @(posedge CPU_CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [31:0] pf;
    bit [31:0] pe;
    bit [1:0]  fe;

    CPU_RST_N    = 1'b0;
    PCF          = '0;
    UpdE         = 1'b0;
    PCE          = '0;
    BrTargetE    = '0;
    TakenE       = 1'b0;
    BranchFlagsE = '0;

    // Clear walk: 64 cycles of not-ready, prediction gated, updates dropped.
    do_reset(2);
    for (int k = 0; k < ENT; k++) begin
      do_cycle($urandom, 1'($urandom), 32'h100, 32'h80, 1'b1, 2'b00);
    end
    do_cycle(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_ready_cycle65", obs_ready, 1'b1);
    chk("tp_init_update_dropped", obs_flags, 2'b00);

    // Miss-taken allocation
    do_cycle(32'h0, 1'b1, 32'h100, 32'h80, 1'b1, 2'b00);
    chk("tp_alloc_redirect", obs_redir, 1'b1);
    chk("tp_alloc_redirect_pc", obs_rpc, 32'h80);
    do_cycle(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_alloc_flags", obs_flags, 2'b11);
    chk("tp_alloc_target", obs_tgt, 32'h80);

    // Two not-taken resolutions walk the counter 10 -> 01 -> 00
    do_cycle(32'h0, 1'b1, 32'h100, 32'h80, 1'b0, 2'b11);
    chk("tp_nt1_redirect", obs_redir, 1'b1);
    chk("tp_nt1_redirect_pc", obs_rpc, 32'h104);
    do_cycle(32'h0, 1'b1, 32'h100, 32'h80, 1'b0, 2'b10);
    chk("tp_nt2_redirect", obs_redir, 1'b0);
    do_cycle(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_nt_flags", obs_flags, 2'b10);

    // Climb back to 3, then saturate; last taken update refreshes the target
    do_cycle(32'h0, 1'b1, 32'h100, 32'h80, 1'b1, 2'b10);
    do_cycle(32'h0, 1'b1, 32'h100, 32'h80, 1'b1, 2'b10);
    do_cycle(32'h0, 1'b1, 32'h100, 32'h80, 1'b1, 2'b11);
    for (int k = 0; k < 3; k++) begin
      do_cycle(32'h0, 1'b1, 32'h100, (k == 2) ? 32'h90 : 32'h80, 1'b1, 2'b11);
      chk("tp_sat_redirect", obs_redir, 1'b0);
    end
    // One not-taken from 3 must still predict taken (no wrap at the top)
    do_cycle(32'h0, 1'b1, 32'h100, 32'h90, 1'b0, 2'b11);
    do_cycle(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_sat_flags", obs_flags, 2'b11);
    chk("tp_sat_target", obs_tgt, 32'h90);

    // Alias 0x200 shares slot 0 with 0x100 and evicts it
    do_cycle(32'h0, 1'b1, 32'h200, 32'h300, 1'b1, 2'b00);
    chk("tp_alias_redirect", obs_redir, 1'b1);
    do_cycle(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_alias_evicted", obs_flags, 2'b00);
    do_cycle(32'h200, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_alias_flags", obs_flags, 2'b11);
    chk("tp_alias_target", obs_tgt, 32'h300);

    // PCE+4 wraps; no redirect without UpdE
    do_cycle(32'h0, 1'b1, 32'hFFFF_FFFC, 32'h40, 1'b0, 2'b00);
    chk("tp_wrap_redirect_pc", obs_rpc, 32'h0);
    chk("tp_wrap_redirect", obs_redir, 1'b0);
    do_cycle(32'h0, 1'b0, 32'h100, 32'h80, 1'b1, 2'b00);
    chk("tp_noupd_redirect", obs_redir, 1'b0);

    // Randomized traffic over a small aliasing PC pool
    for (int k = 0; k < 400; k++) begin
      pf = pool[$urandom_range(0, 7)];
      pe = pool[$urandom_range(0, 7)];
      fe = ($urandom_range(0, 7) == 0) ? 2'($urandom) : m_flags(pe);
      do_cycle(pf, $urandom_range(0, 3) != 0, pe, $urandom & 32'hFFFF_FFFC, 1'($urandom), fe);
    end

    // Make sure 0x100 is resident and taken before resetting
    do_cycle(32'h0, 1'b1, 32'h100, 32'h500, 1'b1, m_flags(32'h100));
    do_cycle(32'h0, 1'b1, 32'h100, 32'h500, 1'b1, m_flags(32'h100));
    do_cycle(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_pre_reset_flags", obs_flags, 2'b11);

    // Reset mid-RUN, then again 30 cycles into the clear walk
    do_reset(1);
    for (int k = 0; k < 30; k++) begin
      do_cycle($urandom, 1'($urandom), 32'h100, 32'h80, 1'b1, 2'b00);
    end
    do_reset(1);
    for (int k = 0; k < ENT; k++) begin
      do_cycle($urandom, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    end
    do_cycle(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("tp_rst_ready65", obs_ready, 1'b1);
    chk("tp_rst_entry_gone", obs_flags, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
